muldiv_unit: RTL and testbench

//   Iterative 16-bit multiply/divide execution unit. Operands come from the register file

---
 rtl/muldiv_if.sv | 20 ++
 rtl/muldiv_unit.sv | 148 ++++++++++++++
 tb/tb_muldiv_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Issue/writeback bundle between the controller and the iterative multiply/divide unit.
interface muldiv_if #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned REGBITS = 4
);
   logic               start;
   logic [1:0]         op;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic [REGBITS-1:0] dest;
   logic               busy;
   logic               wb_en;
   logic [REGBITS-1:0] wb_addr;
   logic [WIDTH-1:0]   wb_data;

   modport master (output start, op, a, b, dest,
                   input  busy, wb_en, wb_addr, wb_data);
   modport slave  (input  start, op, a, b, dest,
                   output busy, wb_en, wb_addr, wb_data);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit, one bit per clock, single writeback pulse.
// Divider datapath present only when MULDIV_DIV_EN is defined; otherwise ops 10/11 return 0.
module muldiv_unit #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned REGBITS = 4
) (
   input  logic     clk,
   input  logic     reset,
   muldiv_if.slave  bus
);
   localparam int unsigned CNTW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e               state_q, state_d;
   logic [CNTW-1:0]      cnt_q, cnt_d;
   logic [1:0]           op_q, op_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [REGBITS-1:0]   dest_q, dest_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d, prod_step;
   logic [WIDTH:0]       add_sum;
   logic                 last_c;
   logic [WIDTH-1:0]     result_c;
   logic                 busy_q, wb_en_q;
   logic [REGBITS-1:0]   wb_addr_q;
   logic [WIDTH-1:0]     wb_data_q;

`ifdef MULDIV_DIV_EN
   logic [WIDTH-1:0]     b_q, b_d, quo_q, quo_d, rem_q, rem_d, quo_step, rem_step;
   logic [WIDTH:0]       div_shift;
   logic                 div_ge;

   // Restoring division: shift in next dividend bit, subtract divisor if it fits
   always_comb begin
      div_shift = {rem_q, quo_q[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, b_q});
      rem_step  = div_ge ? (div_shift[WIDTH-1:0] - b_q) : div_shift[WIDTH-1:0];
      quo_step  = {quo_q[WIDTH-2:0], div_ge};
   end
`endif

   // Shift-add: multiplier sits in the low half and is consumed LSB first
   always_comb begin
      add_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + ({1'b0, a_q} & {(WIDTH+1){prod_q[0]}});
      prod_step = {add_sum, prod_q[WIDTH-1:1]};
   end

   assign last_c = (cnt_q == CNTW'(WIDTH-1));

   always_comb begin
      case (op_q)
         2'b00:   result_c = prod_step[WIDTH-1:0];
         2'b01:   result_c = prod_step[2*WIDTH-1:WIDTH];
`ifdef MULDIV_DIV_EN
         2'b10:   result_c = quo_step;
         2'b11:   result_c = rem_step;
`endif
         default: result_c = '0;
      endcase
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      dest_d  = dest_q;
      prod_d  = prod_q;
`ifdef MULDIV_DIV_EN
      b_d     = b_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_RUN;
               cnt_d   = '0;
               op_d    = bus.op;
               a_d     = bus.a;
               dest_d  = bus.dest;
               prod_d  = {WIDTH'(0), bus.b};
`ifdef MULDIV_DIV_EN
               b_d     = bus.b;
               quo_d   = bus.a;
               rem_d   = '0;
`endif
            end
         end
         S_RUN: begin
            cnt_d  = cnt_q + CNTW'(1);
            prod_d = prod_step;
`ifdef MULDIV_DIV_EN
            quo_d  = quo_step;
            rem_d  = rem_step;
`endif
            if (last_c) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         a_q       <= '0;
         dest_q    <= '0;
         prod_q    <= '0;
         busy_q    <= 1'b0;
         wb_en_q   <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
`ifdef MULDIV_DIV_EN
         b_q       <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         dest_q  <= dest_d;
         prod_q  <= prod_d;
         busy_q  <= (state_d != S_IDLE);
         wb_en_q <= (state_d == S_DONE);
         // Result is latched on the final iteration so it is stable throughout DONE
         if (state_q == S_RUN && last_c) begin
            wb_addr_q <= dest_q;
            wb_data_q <= result_c;
         end
`ifdef MULDIV_DIV_EN
         b_q   <= b_d;
         quo_q <= quo_d;
         rem_q <= rem_d;
`endif
      end
   end

   assign bus.busy    = busy_q;
   assign bus.wb_en   = wb_en_q;
   assign bus.wb_addr = wb_addr_q;
   assign bus.wb_data = wb_data_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, handshake, results, busy-drop and reset abort.
module tb_muldiv_unit;
   logic clk = 1'b0;
   logic reset;
   int   vectors    = 0;
   int   miscompares = 0;

   muldiv_if #(.WIDTH(16), .REGBITS(4)) bus ();

   muldiv_unit #(.WIDTH(16), .REGBITS(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

`ifdef MULDIV_DIV_EN
   localparam bit DIV_ON = 1'b1;
`else
   localparam bit DIV_ON = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] div_exp(input logic [15:0] v);
      return DIV_ON ? v : 16'h0000;
   endfunction

   // Issues one op in cycle 0, scrambles inputs afterwards, checks busy/wb_en each cycle
   // through cycle 17 and the writeback payload there. j1/j2 inject ignored 9*9 starts.
   task automatic run_op(input string tag, input logic [1:0] op_v, input logic [15:0] a_v,
                         input logic [15:0] b_v, input logic [3:0] d_v,
                         input logic [15:0] exp, input int j1, input int j2);
      @(posedge clk); #1;
      chk({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, ".idle_wb"},   32'(bus.wb_en), 32'd0);
      bus.start = 1'b1; bus.op = op_v; bus.a = a_v; bus.b = b_v; bus.dest = d_v;
      for (int k = 1; k <= 17; k++) begin
         @(posedge clk); #1;
         chk($sformatf("%s.busy%0d", tag, k), 32'(bus.busy), 32'd1);
         chk($sformatf("%s.wb%0d", tag, k), 32'(bus.wb_en), 32'(k == 17));
         if (k == j1 || k == j2) begin
            bus.start = 1'b1; bus.op = 2'b00; bus.a = 16'h0009; bus.b = 16'h0009; bus.dest = 4'd2;
         end else begin
            bus.start = 1'b0;
            bus.op = 2'($urandom); bus.a = 16'($urandom); bus.b = 16'($urandom);
            bus.dest = 4'($urandom);
         end
      end
      chk({tag, ".addr"}, 32'(bus.wb_addr), 32'(d_v));
      chk({tag, ".data"}, 32'(bus.wb_data), 32'(exp));
   endtask

   initial begin
      reset = 1'b1;
      bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0; bus.dest = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.busy", 32'(bus.busy), 32'd0);
      chk("rst.wb_en", 32'(bus.wb_en), 32'd0);
      chk("rst.addr", 32'(bus.wb_addr), 32'd0);
      chk("rst.data", 32'(bus.wb_data), 32'd0);
      reset = 1'b0;

      run_op("mullo_1234", 2'b00, 16'h1234, 16'h0010, 4'd3, 16'h2340, -1, -1);
      // Cycle 18: back in IDLE, payload held
      @(posedge clk); #1;
      chk("hold.busy", 32'(bus.busy), 32'd0);
      chk("hold.wb_en", 32'(bus.wb_en), 32'd0);
      chk("hold.addr", 32'(bus.wb_addr), 32'd3);
      chk("hold.data", 32'(bus.wb_data), 32'h2340);

      run_op("mulhi_ffff", 2'b01, 16'hFFFF, 16'hFFFF, 4'd4, 16'hFFFE, -1, -1);
      run_op("mullo_ffff", 2'b00, 16'hFFFF, 16'hFFFF, 4'd5, 16'h0001, -1, -1);
      run_op("divu_100_7", 2'b10, 16'd100, 16'd7, 4'd6, div_exp(16'h000E), -1, -1);
      run_op("remu_100_7", 2'b11, 16'd100, 16'd7, 4'd7, div_exp(16'h0002), -1, -1);
      run_op("divu_by0",   2'b10, 16'h1234, 16'h0000, 4'd0, div_exp(16'hFFFF), -1, -1);
      run_op("remu_by0",   2'b11, 16'h1234, 16'h0000, 4'd8, div_exp(16'h1234), -1, -1);

      // Starts in cycles 4 and 17 (DONE) are dropped; start in cycle 18 is accepted
      run_op("busy_drop", 2'b00, 16'd3, 16'd5, 4'd1, 16'h000F, 4, 17);
      run_op("after_done", 2'b00, 16'd9, 16'd9, 4'd2, 16'h0051, -1, -1);

      // Reset asserted in cycle 6 of a run
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = 2'b00; bus.a = 16'h1234; bus.b = 16'h0010; bus.dest = 4'd9;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         chk($sformatf("abort.busy%0d", k), 32'(bus.busy), 32'd1);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort.busy7", 32'(bus.busy), 32'd0);
      chk("abort.data7", 32'(bus.wb_data), 32'd0);
      for (int k = 8; k <= 24; k++) begin
         @(posedge clk); #1;
         chk($sformatf("abort.wb%0d", k), 32'(bus.wb_en), 32'd0);
         chk($sformatf("abort.idle%0d", k), 32'(bus.busy), 32'd0);
      end
      run_op("post_rst", 2'b00, 16'd2, 16'd2, 4'd10, 16'h0004, -1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
